multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers, power of two, min 4; AW = log2(NREGS).
REQ-003 Parameter NRD, default 4, number of read ports, min 1.
REQ-004 Parameter NWR, default 2, number of write ports, min 1.
REQ-005 Parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to reads.
REQ-006 Parameters SP_INIT, default 32'h7ffffff0, and GP_INIT, default 32'h10000000, give the init values of x2 and x3.
REQ-007 The block SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-008 clk  input  1  clock; all state changes on posedge.
REQ-009 rst  input  1  asynchronous active-high reset.
REQ-010 rd_addr  input  NRD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-011 rd_data  output  NRD*XLEN  combinational read data, port i at [i*XLEN +: XLEN].
REQ-012 wr_en  input  NWR  per-port write enable.
REQ-013 wr_addr  input  NWR*AW  write addresses, port j at [j*AW +: AW].
REQ-014 wr_data  input  NWR*XLEN  write data, port j at [j*XLEN +: XLEN].
REQ-015 clr_req  input  1  single-cycle request to re-run initialisation.
REQ-016 init_done  output  1  high when the file is initialised and accepting writes.

Function
REQ-017 State machine has two states, INIT and READY; INIT clears one register per cycle using a counter idx (AW bits).
REQ-018 In INIT, each posedge writes register idx (SP_INIT for idx 2, GP_INIT for idx 3, zero otherwise), then increments idx.
REQ-019 INIT -> READY on the posedge that writes idx = NREGS-1; INIT therefore lasts exactly NREGS-1 cycles (idx 1..NREGS-1).
REQ-020 READY -> INIT, with idx reloaded to 1, on a posedge with clr_req=1; writes presented in that same cycle are discarded.
REQ-021 clr_req SHALL be ignored while in INIT.
REQ-022 init_done SHALL equal (state == READY), registered, with no combinational path from inputs.
REQ-023 While in INIT, all wr_en SHALL be ignored and every rd_data port SHALL return zero.
REQ-024 In READY, a port j with wr_en[j]=1 and wr_addr != 0 SHALL update its register at the posedge; write-to-read latency is one cycle.
REQ-025 Writes to x0 SHALL be discarded; reads of x0 SHALL return zero on every port regardless of bypass.
REQ-026 When several write ports target the same nonzero address in one cycle, the highest-index port SHALL win.
REQ-027 With BYPASS=1 in READY, a read whose address matches an enabled same-cycle write SHALL return that write's data (highest-index matching port), otherwise the stored value.
REQ-028 With BYPASS=0, reads SHALL always return the stored value (old value during a same-cycle write).
REQ-029 Read ports SHALL be independent; any number of ports may read the same address.
REQ-030 x0 SHALL NOT be implemented as storage.

Reset
REQ-031 Asserting rst SHALL force state=INIT, idx=1 and init_done=0 immediately, independent of clk.
REQ-032 Register contents are not reset directly; they are defined only after INIT completes.
REQ-033 rst asserted mid-INIT or mid-READY SHALL restart INIT from idx=1 after deassertion.
REQ-034 After rst deasserts, init_done SHALL rise on the (NREGS-1)th posedge.

Verification
REQ-035 Defaults, rst pulse then release -> init_done=0 for 30 posedges and 1 after the 31st; x2 reads 7ffffff0, x3 reads 10000000, x1 and x4..x31 read 0.
REQ-036 READY, wr0 x5=0xA5A5A5A5 and wr1 x5=0x12345678 in the same cycle, rd0 reads x5 -> same-cycle read 0x12345678 (BYPASS=1); next cycle 0x12345678 stored.
REQ-037 BYPASS=0 build, x7 holds 0x11, write x7=0x22 with read of x7 in the same cycle -> 0x11 that cycle, 0x22 next cycle.
REQ-038 Write x0=0xFFFFFFFF on both ports -> all ports reading x0 return 0, both same cycle and later.
REQ-039 READY, x9=0x55, clr_req pulse with a concurrent write x9=0x66 -> init_done falls next edge, writes ignored for 31 cycles, x9 reads 0 afterwards.
REQ-040 rst asserted asynchronously between edges at idx=10 of INIT -> init_done stays 0, completion takes a full 31 posedges after release.

Source files
------------

// File: rtl/multiport_regfile_if.sv
// Bundle of read/write port signals for the multiport register file.
// The register file takes the slave side; whoever drives reads and writes takes the master side.
interface multiport_regfile_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 4,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                clr_req;
    logic                init_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, init_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, init_done
    );
endinterface

// File: rtl/multiport_regfile.sv
// Multiport register file with a hard-wired zero x0 and a sequential initialisation sweep.
// Reads are combinational, with optional same-cycle write forwarding.
//
// state | meaning
// INIT  | sweeping idx 1..NREGS-1, loading init values; writes ignored, reads return 0
// READY | normal operation; writes land at posedge, clr_req restarts INIT
module multiport_regfile #(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              NRD     = 4,
    parameter int              NWR     = 2,
    parameter int              BYPASS  = 1,
    parameter logic [XLEN-1:0] SP_INIT = 32'h7ffffff0,
    parameter logic [XLEN-1:0] GP_INIT = 32'h10000000
) (
    input  logic                clk,
    input  logic                rst,
    multiport_regfile_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [0:0] {INIT, READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    logic [NRD*XLEN-1:0] rd_all;
    logic [AW-1:0]       ra;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     word;

    function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] r);
        if (r == AW'(2)) return SP_INIT;
        if (r == AW'(3)) return GP_INIT;
        return '0;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = READY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    state_d = INIT;
                    idx_d   = AW'(1);
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = AW'(1);
            end
        endcase
    end

    // Port loop runs in ascending order so the highest-index write port wins a collision.
    always_comb begin
        regs_d = regs_q;
        wa     = '0;
        if (state_q == INIT) begin
            if (idx_q != '0) begin
                regs_d[idx_q] = init_val(idx_q);
            end
        end else if (!bus.clr_req) begin
            for (int j = 0; j < NWR; j++) begin
                wa = bus.wr_addr[j*AW +: AW];
                if (bus.wr_en[j] && wa != '0) begin
                    regs_d[wa] = bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Forwarding follows the same write qualification as storage, so a discarded write is never seen.
    always_comb begin
        rd_all = '0;
        ra     = '0;
        word   = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = bus.rd_addr[i*AW +: AW];
            word = '0;
            if (state_q == READY && ra != '0) begin
                word = regs_q[ra];
                if (BYPASS != 0 && !bus.clr_req) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
                            word = bus.wr_data[j*XLEN +: XLEN];
                        end
                    end
                end
            end
            rd_all[i*XLEN +: XLEN] = word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign bus.rd_data   = rd_all;
    assign bus.init_done = (state_q == READY);
endmodule

// File: tb/tb_multiport_regfile.sv
// Directed self-checking bench: one forwarding instance and one non-forwarding instance.
module tb_multiport_regfile;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiport_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifa ();
    multiport_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifb ();

    multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_init(input int r);
        if (r == 2) return 32'h7ffffff0;
        if (r == 3) return 32'h10000000;
        return 32'h0;
    endfunction

    task automatic a_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        ifa.wr_en[p]             = en;
        ifa.wr_addr[p*AW +: AW]  = a;
        ifa.wr_data[p*32 +: 32]  = d;
    endtask

    task automatic b_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        ifb.wr_en[p]             = en;
        ifb.wr_addr[p*AW +: AW]  = a;
        ifb.wr_data[p*32 +: 32]  = d;
    endtask

    task automatic a_ra(input int p, input logic [AW-1:0] a);
        ifa.rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [31:0] a_rd(input int p);
        return ifa.rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] b_rd(input int p);
        return ifb.rd_data[p*32 +: 32];
    endfunction

    // INIT lasts NREGS-1 posedges: low after each of the first 30, high after the 31st.
    task automatic wait_init(input string tag);
        for (int k = 1; k <= NREGS - 2; k++) begin
            tick();
            chk({tag, "_low"}, 32'(ifa.init_done), 32'h0);
        end
        tick();
        chk({tag, "_high"}, 32'(ifa.init_done), 32'h1);
    endtask

    initial begin
        ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.clr_req = 1'b0;
        ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.clr_req = 1'b0;
        rst = 1'b1;
        a_ra(0, 5'd2);
        #2;
        chk("rst_done_a", 32'(ifa.init_done), 32'h0);
        chk("rst_done_b", 32'(ifb.init_done), 32'h0);
        chk("rst_rd_zero", a_rd(0), 32'h0);

        tick();
        tick();
        rst = 1'b0;
        wait_init("init");
        chk("init_done_b", 32'(ifb.init_done), 32'h1);

        for (int r = 0; r < NREGS; r++) begin
            for (int p = 0; p < NRD; p++) a_ra(p, AW'(r));
            #1;
            for (int p = 0; p < NRD; p++) chk($sformatf("init_x%0d_p%0d", r, p), a_rd(p), exp_init(r));
            tick();
        end

        a_ra(0, 5'd2); a_ra(1, 5'd3); a_ra(2, 5'd0); a_ra(3, 5'd31);
        #1;
        chk("mix_p0_x2", a_rd(0), 32'h7ffffff0);
        chk("mix_p1_x3", a_rd(1), 32'h10000000);
        chk("mix_p2_x0", a_rd(2), 32'h0);
        chk("mix_p3_x31", a_rd(3), 32'h0);
        tick();

        // Same-address collision: port 1 wins, forwarded and stored.
        a_wr(0, 1'b1, 5'd5, 32'hA5A5A5A5);
        a_wr(1, 1'b1, 5'd5, 32'h12345678);
        a_ra(0, 5'd5); a_ra(1, 5'd6);
        #1;
        chk("coll_bypass", a_rd(0), 32'h12345678);
        chk("coll_other", a_rd(1), 32'h0);
        tick();
        a_wr(0, 1'b0, 5'd0, 32'h0);
        a_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("coll_stored", a_rd(0), 32'h12345678);
        tick();

        a_wr(0, 1'b1, 5'd6, 32'hCAFEF00D);
        a_wr(1, 1'b1, 5'd8, 32'hBEEF0001);
        a_ra(2, 5'd6); a_ra(3, 5'd8);
        #1;
        chk("dual_byp_x6", a_rd(2), 32'hCAFEF00D);
        chk("dual_byp_x8", a_rd(3), 32'hBEEF0001);
        tick();
        a_wr(0, 1'b0, 5'd0, 32'h0);
        a_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("dual_st_x6", a_rd(2), 32'hCAFEF00D);
        chk("dual_st_x8", a_rd(3), 32'hBEEF0001);
        chk("dual_x5_kept", a_rd(0), 32'h12345678);
        tick();

        a_wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        a_wr(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        for (int p = 0; p < NRD; p++) a_ra(p, 5'd0);
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("x0_same_p%0d", p), a_rd(p), 32'h0);
        tick();
        a_wr(0, 1'b0, 5'd0, 32'h0);
        a_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("x0_later_p%0d", p), a_rd(p), 32'h0);
        tick();

        // Same stimulus to both builds: forwarding vs. old value in the write cycle.
        a_wr(0, 1'b1, 5'd7, 32'h11);
        b_wr(0, 1'b1, 5'd7, 32'h11);
        tick();
        a_wr(0, 1'b0, 5'd0, 32'h0);
        b_wr(0, 1'b0, 5'd0, 32'h0);
        a_wr(1, 1'b1, 5'd7, 32'h22);
        b_wr(1, 1'b1, 5'd7, 32'h22);
        a_ra(0, 5'd7);
        ifb.rd_addr[0 +: AW] = 5'd7;
        #1;
        chk("nb_old_val", b_rd(0), 32'h11);
        chk("byp_new_val", a_rd(0), 32'h22);
        tick();
        a_wr(1, 1'b0, 5'd0, 32'h0);
        b_wr(1, 1'b0, 5'd0, 32'h0);
        #1;
        chk("nb_stored", b_rd(0), 32'h22);
        chk("byp_stored", a_rd(0), 32'h22);
        tick();

        a_wr(0, 1'b1, 5'd9, 32'h55);
        a_wr(1, 1'b1, 5'd2, 32'hDEAD0002);
        tick();
        a_wr(1, 1'b0, 5'd0, 32'h0);
        a_wr(0, 1'b0, 5'd0, 32'h0);
        a_ra(0, 5'd9); a_ra(1, 5'd2);
        #1;
        chk("clr_pre_x9", a_rd(0), 32'h55);
        chk("clr_pre_x2", a_rd(1), 32'hDEAD0002);
        tick();
        ifa.clr_req = 1'b1;
        a_wr(0, 1'b1, 5'd9, 32'h66);
        #1;
        chk("clr_cycle_done", 32'(ifa.init_done), 32'h1);
        tick();
        ifa.clr_req = 1'b0;
        a_wr(0, 1'b1, 5'd9, 32'h77);
        #1;
        chk("clr_done_fell", 32'(ifa.init_done), 32'h0);
        chk("clr_rd_zero", a_rd(0), 32'h0);
        ifa.clr_req = 1'b1;
        wait_init("clr");
        ifa.clr_req = 1'b0;
        a_wr(0, 1'b0, 5'd0, 32'h0);
        a_ra(2, 5'd5);
        #1;
        chk("clr_x9_zero", a_rd(0), 32'h0);
        chk("clr_x2_init", a_rd(1), 32'h7ffffff0);
        chk("clr_x5_zero", a_rd(2), 32'h0);
        tick();

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_done", 32'(ifa.init_done), 32'h0);
        chk("async_rst_rd", a_rd(1), 32'h0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("mid_init_done", 32'(ifa.init_done), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_done", 32'(ifa.init_done), 32'h0);
        #1;
        rst = 1'b0;
        wait_init("rerun");
        a_ra(0, 5'd3);
        #1;
        chk("rerun_x3", a_rd(0), 32'h10000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
